// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared definitions for the branch predict unit: funct3 codes
//               for conditional branches, the table-sweep FSM state encoding
//               and saturating-counter constants derived from the width.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Conditional branch funct3 encodings
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // INIT sweeps the tables after reset, RUN predicts and trains
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bpu_state_t;

    // Largest counter value (strongly taken)
    function automatic int ctr_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Weakly not-taken: one below the taken threshold
    function automatic int ctr_weak_nt(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_compare.sv
`default_nettype none
// ============================================================================
// Module      : branch_compare
// Description : Combinational branch condition evaluation. Compares two
//               operands according to the conditional-branch funct3 code.
//               Unknown funct3 codes evaluate as not taken.
// Ports       : funct3 - branch type
//               rs1    - first operand
//               rs2    - second operand
//               cond   - branch condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:     cond = (rs1 == rs2);
            BNE:     cond = (rs1 != rs2);
            BLT:     cond = ($signed(rs1) <  $signed(rs2));
            BGE:     cond = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond = (rs1 <  rs2);
            BGEU:    cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : EX-stage branch resolution plus fetch-stage prediction.
//               A direct-mapped table holds, per index, a saturating
//               direction counter and a tagged target (BTB). Prediction is a
//               combinational read at if_pc; training is a clocked write at
//               ex_pc. After reset the tables are swept for BHT_ENTRIES
//               cycles before prediction is enabled.
// Ports       : clk, rst (sync, active high)
//               if_pc -> pred_taken, pred_target          (fetch prediction)
//               ex_valid/ex_branch/ex_jump/ex_funct3/ex_rs1/ex_rs2/ex_pc/
//               ex_target/ex_pred_taken/ex_pred_target    (EX resolution)
//               ex_taken, mispredict, redirect_pc         (resolution result)
//               init_done                                 (sweep complete)
// Option      : BPU_STATS_EN adds stat_branches / stat_mispredicts counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int TAG_BITS    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            init_done
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] C_CTR_MAX    = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] C_CTR_WEAKNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [IDX-1:0]      C_LAST_IDX   = IDX'(BHT_ENTRIES - 1);

    // Table storage; contents are established by the INIT sweep, not by rst
    logic                r_btb_valid [BHT_ENTRIES];
    logic [CTR_BITS-1:0] r_ctr       [BHT_ENTRIES];
    logic [TAG_BITS-1:0] r_tag       [BHT_ENTRIES];
    logic [XLEN-1:0]     r_target    [BHT_ENTRIES];

    bpu_state_t          r_state;
    logic [IDX-1:0]      r_index;

    logic                w_run;
    logic [IDX-1:0]      w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic [IDX-1:0]      w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_cond;
    logic                w_is_cf;
    logic [CTR_BITS-1:0] w_ctr_old;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_unused_pc_bits;

    assign w_run    = (r_state == RUN);
    assign w_if_idx = if_pc[IDX+1:2];
    assign w_if_tag = if_pc[2+IDX+TAG_BITS-1:2+IDX];
    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_ex_tag = ex_pc[2+IDX+TAG_BITS-1:2+IDX];

    // Byte-offset and high PC bits take no part in indexing or tagging
    assign w_unused_pc_bits = ^{if_pc, ex_pc};

    // ---------------- Prediction (reads the pre-update table) -------------
    assign pred_taken  = w_run & r_btb_valid[w_if_idx]
                       & (r_tag[w_if_idx] == w_if_tag)
                       & r_ctr[w_if_idx][CTR_BITS-1];
    assign pred_target = w_run ? r_target[w_if_idx] : '0;

    // ---------------- Resolution ------------------------------------------
    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .cond   (w_cond)
    );

    // A jump overrides the branch condition when both flags are set
    assign w_is_cf     = ex_valid & (ex_branch | ex_jump);
    assign ex_taken    = ex_valid & (ex_jump | (ex_branch & w_cond));
    assign mispredict  = w_is_cf & ((ex_taken != ex_pred_taken)
                       | (ex_taken & (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));

    // ---------------- Counter update --------------------------------------
    assign w_ctr_old = r_ctr[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_old;
        if (ex_jump) begin
            w_ctr_next = C_CTR_MAX;
        end else if (ex_taken) begin
            if (w_ctr_old != C_CTR_MAX) w_ctr_next = w_ctr_old + 1'b1;
        end else begin
            if (w_ctr_old != '0) w_ctr_next = w_ctr_old - 1'b1;
        end
    end

    // ---------------- Sweep FSM and training ------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_index   <= '0;
            init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_btb_valid[r_index] <= 1'b0;
                    r_ctr[r_index]       <= C_CTR_WEAKNT;
                    r_index              <= r_index + 1'b1;
                    if (r_index == C_LAST_IDX) begin
                        r_state   <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_is_cf) begin
                        r_ctr[w_ex_idx] <= w_ctr_next;
                        if (ex_taken) begin
                            r_btb_valid[w_ex_idx] <= 1'b1;
                            r_tag[w_ex_idx]       <= w_ex_tag;
                            r_target[w_ex_idx]    <= ex_target;
                        end
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_index <= '0;
                end
            endcase
        end
    end

`ifdef BPU_STATS_EN
    // Event counters saturate rather than wrap; active in INIT as well
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (w_is_cf && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit (default
//               parameters). A behavioural model of the prediction tables is
//               compared against the DUT every cycle, with directed literal
//               checks for the key scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int N   = 64;
    localparam int IDX = 6;
    localparam int CMX = 3;      // counter max for 2-bit counters

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken, mispredict;
    logic [31:0] redirect_pc;
    logic        init_done;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_taken       (ex_taken),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .init_done      (init_done)
`ifdef BPU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model -----------------------------------
    bit          m_ready;
    int          m_cnt;
    bit          m_v   [N];
    int          m_c   [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    longint      m_sb, m_sm;

    function automatic bit cond_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken();
        if (!ex_valid) return 1'b0;
        if (ex_jump) return 1'b1;
        return ex_branch && cond_f(ex_funct3, ex_rs1, ex_rs2);
    endfunction

    function automatic bit m_cf();
        return ex_valid && (ex_branch || ex_jump);
    endfunction

    function automatic bit m_misp();
        bit t;
        t = m_taken();
        if (!m_cf()) return 1'b0;
        return (t != ex_pred_taken) || (t && (ex_pred_target != ex_target));
    endfunction

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return (pc >> (2 + IDX)) & 32'hFF;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_sb    = 0;
            m_sm    = 0;
            for (int i = 0; i < N; i++) begin
                m_v[i] = 1'b0;
                m_c[i] = 1;
            end
        end else begin
            if (m_cf() && m_sb < 64'hFFFF_FFFF) m_sb++;
            if (m_misp() && m_sm < 64'hFFFF_FFFF) m_sm++;
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == N) m_ready = 1'b1;
            end else if (m_cf()) begin
                int  i;
                bit  t;
                i = m_index(ex_pc);
                t = m_taken();
                if (ex_jump)  m_c[i] = CMX;
                else if (t)   m_c[i] = (m_c[i] < CMX) ? m_c[i] + 1 : CMX;
                else          m_c[i] = (m_c[i] > 0) ? m_c[i] - 1 : 0;
                if (t) begin
                    m_v[i]   = 1'b1;
                    m_tag[i] = m_tagof(ex_pc);
                    m_tgt[i] = ex_target;
                end
            end
        end
    end

    // ---------------- Per-cycle comparison --------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            int          i;
            bit          ep;
            logic [31:0] er;
            i  = m_index(if_pc);
            ep = m_ready && m_v[i] && (m_tag[i] == m_tagof(if_pc)) && (m_c[i] >= 2);
            er = m_taken() ? ex_target : ex_pc + 32'd4;
            chk("cyc_init_done", {31'b0, init_done}, {31'b0, m_ready});
            chk("cyc_pred_taken", {31'b0, pred_taken}, {31'b0, ep});
            if (ep) chk("cyc_pred_target", pred_target, m_tgt[i]);
            chk("cyc_ex_taken", {31'b0, ex_taken}, {31'b0, m_taken()});
            chk("cyc_mispredict", {31'b0, mispredict}, {31'b0, m_misp()});
            chk("cyc_redirect_pc", redirect_pc, er);
`ifdef BPU_STATS_EN
            chk("cyc_stat_branches", stat_branches, m_sb[31:0]);
            chk("cyc_stat_mispredicts", stat_mispredicts, m_sm[31:0]);
`endif
        end
    end

    // ---------------- Stimulus --------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_funct3 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_pc = 0; ex_target = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic ex_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    logic [31:0] pool [6];

    initial begin
        pool[0] = 32'h40;  pool[1] = 32'h140; pool[2] = 32'h44;
        pool[3] = 32'h1040; pool[4] = 32'h80; pool[5] = 32'h3FC;
        rst = 1; if_pc = 0;
        ex_idle();
        cyc();
        cmp_en = 1;
        cyc();
        rst = 0;

        // Init sweep latency
        for (int k = 1; k <= N; k++) begin
            if_pc = $urandom & 32'hFFFF_FFFC;
            cyc();
            if (k == 10) chk("init_pred_taken", {31'b0, pred_taken}, 32'd0);
            if (k == N - 1) chk("init_done_early", {31'b0, init_done}, 32'd0);
            if (k == N) chk("init_done_rise", {31'b0, init_done}, 32'd1);
        end

        // BLT signed vs BLTU on the same operands
        ex_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h100);
        #1;
        chk("blt_taken", {31'b0, ex_taken}, 32'd1);
        chk("blt_misp", {31'b0, mispredict}, 32'd1);
        chk("blt_redirect", redirect_pc, 32'h100);
        cyc();
        ex_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h100);
        #1;
        chk("bltu_taken", {31'b0, ex_taken}, 32'd0);
        chk("bltu_misp", {31'b0, mispredict}, 32'd0);
        chk("bltu_redirect", redirect_pc, 32'h204);
        cyc();

        // Training at pc 0x40 -> 0x80
        ex_br(3'b000, 32'd5, 32'd5, 32'h40, 32'h80);
        cyc();
        cyc();
        ex_idle();
        if_pc = 32'h40;
        #1;
        chk("train_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("train_pred_target", pred_target, 32'h80);
        ex_br(3'b001, 32'd5, 32'd5, 32'h40, 32'h80);
        cyc(); cyc(); cyc();
        ex_idle();
        #1;
        chk("nt3_pred_taken", {31'b0, pred_taken}, 32'd0);
        ex_br(3'b001, 32'd5, 32'd5, 32'h40, 32'h80);
        cyc();
        ex_br(3'b000, 32'd5, 32'd5, 32'h40, 32'h80);
        cyc();
        ex_idle();
        #1;
        chk("sat0_one_taken", {31'b0, pred_taken}, 32'd0);
        ex_br(3'b000, 32'd5, 32'd5, 32'h40, 32'h80);
        cyc();
        ex_idle();
        #1;
        chk("sat0_two_taken", {31'b0, pred_taken}, 32'd1);

        // Aliasing: same index, different tag
        if_pc = 32'h40 + 32'd4 * N;
        #1;
        chk("alias_pred_taken", {31'b0, pred_taken}, 32'd0);

        // Jump with correct and wrong predicted target; PC wrap on fall-through
        ex_valid = 1; ex_jump = 1; ex_branch = 1; ex_funct3 = 3'b000;
        ex_rs1 = 1; ex_rs2 = 2; ex_pc = 32'h300; ex_target = 32'h500;
        ex_pred_taken = 1; ex_pred_target = 32'h500;
        #1;
        chk("jal_taken", {31'b0, ex_taken}, 32'd1);
        chk("jal_misp_ok", {31'b0, mispredict}, 32'd0);
        ex_pred_target = 32'h504;
        #1;
        chk("jal_misp_tgt", {31'b0, mispredict}, 32'd1);
        cyc();
        ex_br(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10);
        #1;
        chk("wrap_redirect", redirect_pc, 32'h0);
        cyc();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            if_pc          = pool[$urandom_range(0, 5)];
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_branch      = $urandom_range(0, 1);
            ex_jump        = ($urandom_range(0, 4) == 0);
            ex_funct3      = 3'($urandom_range(0, 7));
            ex_rs1         = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
            ex_rs2         = ($urandom_range(0, 2) == 0) ? ex_rs1 : 32'($urandom_range(0, 3));
            ex_pc          = pool[$urandom_range(0, 5)];
            ex_target      = ($urandom_range(0, 1) != 0) ? 32'h80 : ($urandom & 32'hFFFF_FFFC);
            ex_pred_taken  = $urandom_range(0, 1);
            ex_pred_target = ($urandom_range(0, 1) != 0) ? ex_target : 32'h80;
            cyc();
        end

        // Reset in the middle of the sweep restarts it
        rst = 1;
        ex_idle();
        cyc();
        rst = 0;
        for (int k = 0; k < 30; k++) cyc();
        rst = 1;
        cyc();
        rst = 0;
        for (int k = 1; k <= N; k++) begin
            cyc();
            if (k == N - 1) chk("restart_done_early", {31'b0, init_done}, 32'd0);
            if (k == N) chk("restart_done_rise", {31'b0, init_done}, 32'd1);
        end
`ifdef BPU_STATS_EN
        chk("stat_branches_clear", stat_branches, 32'd0);
        chk("stat_mispredicts_clear", stat_mispredicts, 32'd0);
`endif
        cyc();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch decision logic. It resolves conditional branches and jumps from raw operands, predicts fetch-stage direction and target with a direct-mapped branch history table (BHT, saturating counters) and a tagged branch target buffer (BTB), and trains both on resolution. It flags mispredicts and supplies the redirect PC to the fetch/hazard logic.

Parameters:
XLEN, 32, operand/PC width
BHT_ENTRIES, 64, table depth; power of two, >=4
CTR_BITS, 2, saturating counter width (1..4)
TAG_BITS, 8, BTB tag width, taken from pc[2+IDX+TAG_BITS-1 : 2+IDX]; IDX = log2(BHT_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  XLEN  fetch PC
pred_taken  out  1  fetch prediction
pred_target  out  XLEN  predicted target; valid when pred_taken=1
ex_valid  in  1  EX-stage instruction valid (not flushed)
ex_branch  in  1  conditional branch
ex_jump  in  1  JAL/JALR
ex_funct3  in  3  branch type
ex_rs1, ex_rs2  in  XLEN  forwarded operands
ex_pc  in  XLEN  PC of the EX instruction
ex_target  in  XLEN  computed target
ex_pred_taken  in  1  prediction carried down the pipe
ex_pred_target  in  XLEN  predicted target carried down the pipe
ex_taken  out  1  resolved direction
mispredict  out  1  redirect required
redirect_pc  out  XLEN  correct next PC
init_done  out  1  table initialisation complete

Behaviour:
- Synchronous active-high reset on clk; outputs and internal state change only at the rising edge of clk.
- Reset: FSM enters INIT, sweep index=0, init_done=0. All registered outputs reset to 0.
- FSM INIT: writes entry[index] = {btb_valid=0, ctr=2^(CTR_BITS-1)-1 (weakly not-taken)}, index++ per cycle. After entry BHT_ENTRIES-1 -> RUN, init_done=1 (latency BHT_ENTRIES cycles after rst deasserts).
- rst asserted mid-INIT or in RUN restarts INIT at index 0.
- During INIT: pred_taken=0, pred_target=0, training writes dropped. ex_taken, mispredict and redirect_pc remain functional.
- Prediction (combinational read, RUN): idx=if_pc[IDX+1:2]. pred_taken = btb_valid & tag match & ctr MSB. pred_target = stored target.
- Resolution (combinational): eq/lt/ltu compare of ex_rs1/ex_rs2 per funct3. BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Other funct3 -> not taken.
- ex_taken = ex_valid & (ex_jump | (ex_branch & cond)). If ex_jump and ex_branch are both set, the jump wins.
- mispredict = ex_valid & (ex_branch|ex_jump) & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc + 4 (mod 2^XLEN, wraps).
- Training (RUN, clocked, when ex_valid & (ex_branch|ex_jump)):
  - Counter: +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - Jump: counter forced to max.
  - BTB: on taken, write tag/target and set btb_valid. On not-taken, leave BTB unchanged.
- Same-cycle read/write to the same index: the read returns the pre-update value (no bypass).

Optional Feature:
BPU_STATS_EN: when defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
- Counts resolved ex_valid branches/jumps and mispredicts.
- Saturates at 0xFFFFFFFF; cleared by rst.
- Counting is active in INIT as well.
When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams (BEQ..BGEU)
  - FSM state encodings INIT/RUN
  - counter max/weak-not-taken constants as functions of CTR_BITS
- Sub-module branch_compare: combinational funct3/operand resolve, XLEN-parametrised. Instantiated once.

Test Plan:
- Reset, defaults (BHT_ENTRIES=64): rst high 1 cycle -> init_done=0 for 64 cycles then 1; pred_taken=0 for any if_pc.
- BLT signed, ex_rs1=0xFFFFFFFF, ex_rs2=1, ex_pred_taken=0, ex_target=0x100 -> ex_taken=1, mispredict=1, redirect_pc=0x100.
- BLTU on the same operands -> ex_taken=0, mispredict=0, redirect_pc=ex_pc+4.
- Training at pc=0x40, target=0x80:
  - 2 taken resolutions -> if_pc=0x40 gives pred_taken=1, pred_target=0x80.
  - 3 not-taken -> pred_taken=0; counter stays saturated at 0 on a 4th.
- Aliasing: train pc=0x40, then probe if_pc=0x40+4*64 -> tag mismatch -> pred_taken=0.
- rst asserted at INIT index 30 -> sweep restarts; init_done rises exactly 64 cycles after rst drops. With BPU_STATS_EN, counters read 0 afterwards.
